// File: rtl/inv_selftest_if.sv
// Bundle between the inverter self-test engine and whatever stimulates it:
// run control, stimulus/response pair and the result statistics.
// The engine uses the slave modport. The master modport is for the side that
// starts runs and returns the inverter response.
interface inv_selftest_if #(
   parameter int WIDTH       = 8,
   parameter int NUM_VECTORS = 16
);
   localparam int CNT_W = $clog2(NUM_VECTORS + 1);
   localparam int IDX_W = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;

   logic             start;
   logic [WIDTH-1:0] stim_o;
   logic [WIDTH-1:0] resp_i;
   logic             busy;
   logic             done;
   logic             pass;
   logic [CNT_W-1:0] pass_cnt;
   logic [CNT_W-1:0] fail_cnt;
   logic [IDX_W-1:0] first_fail_idx;

   modport master (
      output start, resp_i,
      input  stim_o, busy, done, pass, pass_cnt, fail_cnt, first_fail_idx
   );

   modport slave (
      input  start, resp_i,
      output stim_o, busy, done, pass, pass_cnt, fail_cnt, first_fail_idx
   );
endinterface

// File: rtl/inv_selftest.sv
// Built-in self-test engine for inverter-class datapaths.
// Vector k is the low WIDTH bits of k, inverted when k is odd.
// Each vector is driven, held for SETTLE cycles, and then its response is
// checked for a full bitwise inversion.
// Optional feature macro: INV_SELFTEST_STOP_ON_FAIL_EN. When it is defined,
// the first failing vector ends the run.
//
//   state    | meaning
//   S_IDLE   | waiting for start, last vector and results held
//   S_DRIVE  | new vector applied to stim_o (1 cycle)
//   S_SETTLE | settle down-counter running, stim_o held
//   S_CHECK  | resp_i compared against ~stim_o, statistics updated
//   S_DONE   | done pulse, pass valid
module inv_selftest #(
   parameter int WIDTH       = 8,
   parameter int SETTLE      = 4,
   parameter int NUM_VECTORS = 16
) (
   input  logic          clk,
   input  logic          rst,
   inv_selftest_if.slave bus
);
   localparam int CNT_W    = $clog2(NUM_VECTORS + 1);
   localparam int IDX_W    = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
   localparam int SET_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam int SET_LOAD = (SETTLE > 0) ? SETTLE - 1 : 0;

`ifdef INV_SELFTEST_STOP_ON_FAIL_EN
   localparam bit STOP_ON_FAIL = 1'b1;
`else
   localparam bit STOP_ON_FAIL = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DRIVE  = 3'd1,
      S_SETTLE = 3'd2,
      S_CHECK  = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [IDX_W-1:0] r_k;
   logic [IDX_W-1:0] w_k_nxt;
   logic [SET_W-1:0] r_settle_cnt;
   logic [WIDTH-1:0] r_stim;
   logic             r_pass;
   logic [CNT_W-1:0] r_pass_cnt;
   logic [CNT_W-1:0] r_fail_cnt;
   logic [IDX_W-1:0] r_first_fail_idx;
   logic             w_check_fail;
   logic             w_last;

   function automatic logic [WIDTH-1:0] f_vec(input logic [IDX_W-1:0] k);
      logic [WIDTH-1:0] v;
      v = WIDTH'(k);
      if (k[0]) v = ~v;
      return v;
   endfunction

   assign w_check_fail = (bus.resp_i != ~r_stim);
   assign w_last       = (r_k == IDX_W'(NUM_VECTORS - 1));

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state and next-vector-index decode.
   always_comb begin
      w_state_nxt = r_state;
      w_k_nxt     = r_k;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_state_nxt = S_DRIVE;
               w_k_nxt     = '0;
            end
         end
         S_DRIVE:  w_state_nxt = (SETTLE == 0) ? S_CHECK : S_SETTLE;
         S_SETTLE: if (r_settle_cnt == '0) w_state_nxt = S_CHECK;
         S_CHECK: begin
            if (w_last || (STOP_ON_FAIL && w_check_fail)) begin
               w_state_nxt = S_DONE;
            end else begin
               w_state_nxt = S_DRIVE;
               w_k_nxt     = r_k + IDX_W'(1);
            end
         end
         S_DONE:   w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // Vector index, stimulus, settle timer and run statistics.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_k              <= '0;
         r_stim           <= '0;
         r_settle_cnt     <= '0;
         r_pass           <= 1'b0;
         r_pass_cnt       <= '0;
         r_fail_cnt       <= '0;
         r_first_fail_idx <= '0;
      end else begin
         r_k <= w_k_nxt;
         // stim_o takes the new vector on the edge that enters S_DRIVE.
         if (w_state_nxt == S_DRIVE) r_stim <= f_vec(w_k_nxt);
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_pass           <= 1'b0;
                  r_pass_cnt       <= '0;
                  r_fail_cnt       <= '0;
                  r_first_fail_idx <= '0;
               end
            end
            S_DRIVE:  r_settle_cnt <= SET_W'(SET_LOAD);
            S_SETTLE: if (r_settle_cnt != '0) r_settle_cnt <= r_settle_cnt - SET_W'(1);
            S_CHECK: begin
               if (w_check_fail) begin
                  r_fail_cnt <= r_fail_cnt + CNT_W'(1);
                  if (r_fail_cnt == '0) r_first_fail_idx <= r_k;
               end else begin
                  r_pass_cnt <= r_pass_cnt + CNT_W'(1);
               end
               // pass must already be valid during the done cycle.
               if (w_state_nxt == S_DONE) r_pass <= (r_fail_cnt == '0) && !w_check_fail;
            end
            default: ;
         endcase
      end
   end

   assign bus.stim_o         = r_stim;
   assign bus.busy           = (r_state == S_DRIVE) || (r_state == S_SETTLE) || (r_state == S_CHECK);
   assign bus.done           = (r_state == S_DONE);
   assign bus.pass           = r_pass;
   assign bus.pass_cnt       = r_pass_cnt;
   assign bus.fail_cnt       = r_fail_cnt;
   assign bus.first_fail_idx = r_first_fail_idx;
endmodule

// File: tb/tb_inv_selftest.sv
// Bench for inv_selftest. It compares the engine against a vector-level model
// of a run. The model works out the pass/fail outcome of every vector from a
// stuck-at response model, and from that the statistics and the done time.
module tb_inv_selftest;
   localparam int W  = 8;
   localparam int NV = 4;
   localparam int SA = 4;
   localparam int SB = 0;

`ifdef INV_SELFTEST_STOP_ON_FAIL_EN
   localparam bit STOP = 1'b1;
`else
   localparam bit STOP = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] set_mask;
   logic [W-1:0] clr_mask;
   int           total = 0;
   int           bad   = 0;

   always #5 clk = ~clk;

   inv_selftest_if #(.WIDTH(W), .NUM_VECTORS(NV)) ia ();
   inv_selftest_if #(.WIDTH(W), .NUM_VECTORS(NV)) ib ();

   inv_selftest #(.WIDTH(W), .SETTLE(SA), .NUM_VECTORS(NV)) dut_a (.clk(clk), .rst(rst), .bus(ia));
   inv_selftest #(.WIDTH(W), .SETTLE(SB), .NUM_VECTORS(NV)) dut_b (.clk(clk), .rst(rst), .bus(ib));

   // Emulated inverters: A has configurable stuck-at-1/stuck-at-0 bits, B is ideal.
   assign ia.resp_i = (~ia.stim_o | set_mask) & ~clr_mask;
   assign ib.resp_i = ~ib.stim_o;

   function automatic logic [W-1:0] m_vec(input int k);
      logic [W-1:0] v;
      v = k[W-1:0];
      if (k % 2 == 1) v = ~v;
      return v;
   endfunction

   function automatic logic [W-1:0] m_resp(input logic [W-1:0] v);
      return (~v | set_mask) & ~clr_mask;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_a(input string tag);
      chk({tag, "_stim"}, ia.stim_o, 0);
      chk({tag, "_busy"}, ia.busy, 0);
      chk({tag, "_done"}, ia.done, 0);
      chk({tag, "_pass"}, ia.pass, 0);
      chk({tag, "_pcnt"}, ia.pass_cnt, 0);
      chk({tag, "_fcnt"}, ia.fail_cnt, 0);
      chk({tag, "_ffi"},  ia.first_fail_idx, 0);
   endtask

   // One full run on engine A, checked against the model for the current masks.
   task automatic run_a(input bit repulse);
      int exp_p, exp_f, exp_ffi, last_k, exp_cyc, c;
      bit stopped;
      exp_p = 0; exp_f = 0; exp_ffi = 0; last_k = NV - 1; stopped = 0;
      for (int k = 0; k < NV; k++) begin
         if (!stopped) begin
            if (m_resp(m_vec(k)) != ~m_vec(k)) begin
               if (exp_f == 0) exp_ffi = k;
               exp_f++;
               if (STOP) begin
                  stopped = 1;
                  last_k  = k;
               end
            end else begin
               exp_p++;
            end
         end
      end
      exp_cyc = (last_k + 1) * (SA + 2);

      @(negedge clk) ia.start = 1'b1;
      @(negedge clk) ia.start = 1'b0;
      c = 0;
      while (ia.done !== 1'b1 && c < 400) begin
         chk("run_stim", ia.stim_o, m_vec(c / (SA + 2)));
         chk("run_busy", ia.busy, 1);
         @(negedge clk);
         c++;
         ia.start = (repulse && c == 7) ? 1'b1 : 1'b0;
      end
      ia.start = 1'b0;
      chk("done_cyc", c, exp_cyc);
      chk("pass_cnt", ia.pass_cnt, exp_p);
      chk("fail_cnt", ia.fail_cnt, exp_f);
      chk("first_fail_idx", ia.first_fail_idx, exp_ffi);
      chk("pass", ia.pass, (exp_f == 0) ? 1 : 0);
      chk("last_stim", ia.stim_o, m_vec(last_k));
      @(negedge clk);
      chk("done_pulse", ia.done, 0);
      chk("idle_busy", ia.busy, 0);
      chk("pass_hold", ia.pass, (exp_f == 0) ? 1 : 0);
      chk("pcnt_hold", ia.pass_cnt, exp_p);
   endtask

   initial begin
      int c;
      rst      = 1'b1;
      ia.start = 1'b0;
      ib.start = 1'b0;
      set_mask = '0;
      clr_mask = '0;
      repeat (2) @(negedge clk);
      chk_reset_a("rst0");
      chk("rst0_b_busy", ib.busy, 0);
      rst = 1'b0;
      @(negedge clk);

      // Ideal inverter.
      run_a(1'b0);

      // Bit 7 stuck at one.
      set_mask = 8'h80;
      run_a(1'b0);
      set_mask = '0;

      // Random stuck-at patterns, kept sparse so passing and failing vectors mix.
      for (int r = 0; r < 8; r++) begin
         set_mask = W'($urandom & $urandom & $urandom);
         clr_mask = W'($urandom & $urandom & $urandom);
         if (r % 3 == 0) clr_mask = '0;
         run_a(1'b0);
      end
      set_mask = '0;
      clr_mask = '0;

      // Zero settle cycles on engine B.
      @(negedge clk) ib.start = 1'b1;
      @(negedge clk) ib.start = 1'b0;
      c = 0;
      while (ib.done !== 1'b1 && c < 100) begin
         chk("b_stim", ib.stim_o, m_vec(c / (SB + 2)));
         @(negedge clk);
         c++;
      end
      chk("b_done_cyc", c, NV * (SB + 2));
      chk("b_pass_cnt", ib.pass_cnt, NV);
      chk("b_pass", ib.pass, 1);

      // start re-pulsed while busy is ignored.
      run_a(1'b1);

      // Reset in the middle of the second vector.
      @(negedge clk) ia.start = 1'b1;
      @(negedge clk) ia.start = 1'b0;
      repeat (8) @(negedge clk);
      chk("mid_stim", ia.stim_o, m_vec(1));
      chk("mid_pcnt", ia.pass_cnt, 1);
      rst = 1'b1;
      #1;
      chk_reset_a("rstmid");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_no_done", ia.done, 0);
      end
      rst = 1'b0;
      @(negedge clk);
      chk_reset_a("rstpost");

      // Clean run after reset.
      run_a(1'b0);
      chk("final_pass", ia.pass, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
